// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter that frames one requester's byte stream as header, payload and
// XOR-checksum trailer onto the single tx FIFO write port.
module tx_packet_arbiter #(
    parameter int         NREQ      = 3,
    parameter logic [5:0] HDR_TAG   = 6'b101010,
    parameter int         STALL_MAX = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          fifo_wdata,
    output logic                fifo_winc,
    input  logic                fifo_wfull,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                err_timeout,
    input  logic                err_clear
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    // Abort fires on the idle cycle that brings the count up to STALL_MAX.
    localparam logic [15:0] STALL_LIM  = 16'(STALL_MAX - 1);
    localparam logic [1:0]  LAST_RESET = 2'(NREQ - 1);

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [15:0] stall_q, stall_d;
    logic        aborted_q, aborted_d;
    logic        err_q, err_d;

    logic        load_ok_s;
    logic        sel_valid_s;
    logic        sel_last_s;
    logic [7:0]  sel_data_s;
    logic        xfer_s;
    logic [1:0]  pick_s;
    logic [NREQ-1:0] ready_s;

    assign fifo_winc   = out_valid_q & ~fifo_wfull & rst_n;
    assign fifo_wdata  = out_data_q;
    assign load_ok_s   = ~out_valid_q | fifo_winc;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;
    assign req_ready   = ready_s;
    assign xfer_s      = (state_q == ST_PAYLOAD) & sel_valid_s & load_ok_s;

    // Mux the granted requester's handshake and drive its ready.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        ready_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_valid_s = sel_valid_s | (req_valid[i] & (grant_id_q == 2'(i)));
            sel_last_s  = sel_last_s  | (req_last[i]  & (grant_id_q == 2'(i)));
            sel_data_s  = sel_data_s  | (req_data[8*i +: 8] & {8{grant_id_q == 2'(i)}});
            ready_s[i]  = (state_q == ST_PAYLOAD) & (grant_id_q == 2'(i)) & load_ok_s & rst_n;
        end
    end

    // Round-robin pick: the nearest valid index after last_grant wins.
    always_comb begin
        int              idx;
        logic [NREQ-1:0] sh;
        pick_s = grant_id_q;
        idx    = 0;
        sh     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx    = (int'(last_grant_q) + k) % NREQ;
            sh     = req_valid >> idx;
            pick_s = sh[0] ? 2'(idx) : pick_s;
        end
    end

    // Next-state, framing and output-register load.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q & ~fifo_winc;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        checksum_d   = checksum_q;
        stall_d      = stall_q;
        aborted_d    = aborted_q;
        err_d        = err_q & ~err_clear;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_id_d = pick_s;
                    checksum_d = 8'h00;
                    stall_d    = 16'd0;
                    aborted_d  = 1'b0;
                    state_d    = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (load_ok_s) begin
                    out_data_d  = {HDR_TAG, grant_id_q};
                    out_valid_d = 1'b1;
                    state_d     = ST_PAYLOAD;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (xfer_s) begin
                    out_data_d  = sel_data_s;
                    out_valid_d = 1'b1;
                    checksum_d  = csum_step(checksum_q, sel_data_s);
                    stall_d     = 16'd0;
                    state_d     = sel_last_s ? ST_TRAILER : ST_PAYLOAD;
                end else if (!sel_valid_s) begin
                    if (stall_q == STALL_LIM) begin
                        err_d     = 1'b1;
                        aborted_d = 1'b1;
                        stall_d   = 16'd0;
                        state_d   = ST_TRAILER;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end else begin
                    // Back-pressure from the FIFO is not a requester stall.
                    stall_d = stall_q;
                end
            end
            ST_TRAILER: begin
                if (load_ok_s) begin
                    out_data_d   = aborted_q ? csum_step(checksum_q, 8'hFF) : checksum_q;
                    out_valid_d  = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_TRAILER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_RESET;
            grant_id_q   <= 2'd0;
            checksum_q   <= 8'h00;
            stall_q      <= 16'd0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            checksum_q   <= checksum_d;
            stall_q      <= stall_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: doc/tx_packet_arbiter.md
Name: tx_packet_arbiter

Overview:
- Shares the single tx FIFO write port between up to four byte-stream producers: MCP telemetry, CCD pixel readout and command responses.
- Grants one requester at a time in round-robin order and frames each packet as a header byte, the payload bytes, then an XOR checksum trailer.
- Drives the FIFO's wdata/winc/wfull port directly and replaces the ad-hoc per-state winc sequencing in the controller.

Parameters:
- NREQ, 3, number of requesters (2..4); requester index i gives packet id i.
- HDR_TAG, 6'b101010, upper 6 bits of the header byte.
- STALL_MAX, 1024, idle cycles allowed mid-packet before the packet is aborted (range 2..65535).

Ports:
- clk  in  1  system clock; everything is on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte on req_data.
- req_data  in  8*NREQ  byte i occupies bits [8*i+7:8*i].
- req_last  in  NREQ  the byte presented is the last byte of the packet.
- req_ready  out  NREQ  byte accepted when valid and ready are both high.
- fifo_wdata  out  8  byte to the tx FIFO.
- fifo_winc  out  1  FIFO write strobe.
- fifo_wfull  in  1  FIFO full flag.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  2  index of the requester that currently holds the grant.
- err_timeout  out  1  sticky flag: a packet was aborted.
- err_clear  in  1  clears err_timeout.

Behaviour:
- Reset values: state=IDLE, out_valid=0, last_grant=NREQ-1, grant_id=0, checksum=0, stall counter=0, err_timeout=0.
- During reset: fifo_winc=0 and req_ready=0.
- Reset mid-packet discards the held byte. No trailer is emitted.
- Output register: holds out_data and out_valid.
  - fifo_winc = out_valid & ~fifo_wfull (combinational).
  - fifo_wdata = out_data.
  - load_ok = ~out_valid | fifo_winc. The register reloads in the same cycle it drains, giving 1 byte/cycle when the FIFO is not full.
  - winc is never asserted while wfull=1; a held byte waits indefinitely.
- req_ready[i] = (state==PAYLOAD) & (grant_id==i) & load_ok. Only the granted requester can ever see ready.
- Requester rule: once valid is high, data and last are held until transfer.
- IDLE:
  - If any req_valid is high, grant the first index searching last_grant+1, +2, … modulo NREQ.
  - Register grant_id, go to HDR, clear checksum.
  - Requests are sampled in IDLE only, so simultaneous requests are resolved purely by round-robin.
- HDR: when load_ok, load {HDR_TAG, grant_id} and go to PAYLOAD.
- PAYLOAD:
  - On transfer: load the byte, checksum ^= byte, clear the stall counter.
  - If req_last was set on the transfer, go to TRAILER.
  - Stall counter: increments each cycle the granted requester's valid is 0. Cycles stalled by fifo_wfull (valid=1, load_ok=0) do not count.
  - When the counter reaches STALL_MAX: set err_timeout, mark the packet aborted, go to TRAILER.
- TRAILER:
  - When load_ok, load checksum. If the packet was aborted, load checksum^8'hFF instead.
  - Set last_grant=grant_id and go to IDLE.
  - The same requester can next be granted only after the others have had their turn.
- Zero-length packets are impossible: the first payload byte is required, and a last byte ends the packet.
- err_timeout: err_clear=1 clears it. If a timeout occurs in the same cycle as err_clear, set wins.
- Minimum latency: valid high at cycle 0 (in IDLE) → header on fifo_winc at cycle 2 → first payload byte at cycle 3. An N-byte packet occupies N+2 FIFO writes.

Test Plan:
- Requester 1 sends 0x10, 0x22 (last on 0x22), FIFO never full → winc writes exactly A9, 10, 22, 32 on consecutive cycles. busy drops the cycle after the trailer is loaded.
- Requesters 0, 1 and 2 all hold valid from reset, each with 1-byte packets 0x01, 0x02, 0x03 → FIFO sees A8 01 01, A9 02 02, AA 03 03 in that order. A further re-request by 0 is granted only after 2.
- fifo_wfull forced high for 20 cycles mid-payload → no winc while full and no byte lost or duplicated. err_timeout stays 0 even with STALL_MAX=8.
- STALL_MAX=8: requester 2 sends 0x55 then drops valid → after 8 idle cycles the trailer 0xAA (0x55^0xFF) is written and err_timeout=1. err_clear then drops it to 0.
- rst_n low for 1 cycle while the payload byte is held in the output register with wfull=1 → next cycle winc=0, busy=0. A new packet afterwards starts with a header granting requester 0.
- NREQ=4, requester 3 alone sends 256 bytes 0x00..0xFF → header 0xAB, 256 payload bytes in order, trailer 0x00. Throughput is 1 byte/cycle.
